gnn_layer_seq: RTL and testbench
================================

Name: gnn_layer_seq

Overview:
- Parametrised, time-multiplexed single GCN layer for the GNN datapath.
- Computes out[n][j] = sum over m in ({n} ∪ N(n)), sum over i, of x[m][i]·w[i][j], with one shared multiplier.
- Adds a runtime adjacency matrix, optional ReLU, output saturation and a valid/ready handshake on both sides.
- Two instances in series form a two-layer network, e.g. N=4, FI=4, FO=4, then FI=4, FO=2.

Parameters:
- N, 4, number of graph nodes (≥2)
- FI, 4, input features per node
- FO, 2, output features per node
- DW, 5, signed feature width
- WW, 5, signed weight width
- OW, 21, signed output width
- SAT, 1, 1 = saturate to the OW signed range; 0 = keep the low OW bits (wrap)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input frame valid
- in_ready  out  1  block can accept a frame
- x_flat  in  N*FI*DW  features; x[n][i] at bit offset (n*FI+i)*DW, signed
- w_flat  in  FI*FO*WW  weights; w[i][j] at bit offset (i*FO+j)*WW, signed
- adj  in  N*N  bit n*N+m = node m neighbours node n; diagonal ignored, self always included
- relu_en  in  1  clamp negative results to 0
- out_valid  out  1  result frame valid
- out_ready  in  1  downstream accepts the frame
- out_flat  out  N*FO*OW  out[n][j] at bit offset (n*FO+j)*OW
- sat_flag  out  1  at least one result in the current frame saturated or wrapped

Behaviour:
- Reset:
  - State goes to IDLE.
  - in_ready=1, out_valid=0, out_flat=0, sat_flag=0.
  - Counters and the accumulator are cleared.
  - Reset during COMPUTE or DONE aborts the frame with no output.
- Internal accumulator width: ACC_W = DW+WW+clog2(FI)+clog2(N)+1. Accumulation never overflows inside the block.
- States: IDLE → COMPUTE → DONE → IDLE.
- IDLE:
  - in_ready=1.
  - When in_valid&&in_ready is high at an edge, x_flat, w_flat, adj and relu_en are latched, counters n=j=i=0, acc=0, and the state moves to COMPUTE.
  - in_ready is 0 from the next cycle.
- COMPUTE:
  - Loop order: n outermost, then j, then i innermost.
  - Each cycle, agg = sum of x[m][i] over every m with m==n or adj[n*N+m]=1 (combinational, signed).
  - acc_next = acc + agg·w[i][j].
  - When i==FI-1, acc_next is post-processed and written to out[n][j], acc clears to 0, and i wraps to 0 with j incrementing.
  - When j wraps, n increments.
  - After the write for n=N-1, j=FO-1, the state moves to DONE.
  - Total N*FO*FI cycles (32 at defaults).
- Post-processing order: ReLU first (negative → 0 when relu_en), then saturation or wrap to OW.
  - sat_flag is set if any value exceeded the OW range.
  - sat_flag clears on frame accept.
- DONE:
  - out_valid=1. out_flat and sat_flag are stable.
  - out_flat is not updated during COMPUTE writes until DONE; a shadow register is used.
  - Stays in DONE while out_ready=0.
  - On out_valid&&out_ready: out_valid→0, state→IDLE, in_ready=1 in the next cycle.
  - out_flat holds its last value after the handshake.
- Latency: accept edge to out_valid high = N*FO*FI+1 cycles. Throughput is one frame per N*FO*FI+2 cycles when out_ready is tied high.
- Input values change while not in IDLE: ignored, because operands come from the latched copies.
- in_valid held high continuously: the next frame is accepted on the first IDLE cycle.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid.
- adj all-zero: each node aggregates only itself.

Test Plan:
- Max: defaults, ring adjacency (0-1-2-3-0), all x=15, all w=15, relu_en=0 → every out=2700, sat_flag=0, out_valid exactly 33 cycles after accept.
- Min: all x=-16, all w=-16, ring → every out=3072. Repeat with OW=12, SAT=1 → every out=2047, sat_flag=1. Repeat with SAT=0 → every out=-1024 (wrapped), sat_flag=1.
- ReLU: all x=1, w[i][0]=-1, w[i][1]=2, ring → out[n][0]=-12, out[n][1]=24. Repeat with relu_en=1 → 0 and 24.
- Adjacency: adj=0, x[n][i]=n+1, all w=1 → out[n][j]=4(n+1), i.e. 4, 8, 12, 16. Fully connected adj → every out=40.
- Backpressure: out_ready low for 10 cycles in DONE → out_valid and out_flat stay stable and in_ready stays 0. Inputs toggled during COMPUTE do not change results. Back-to-back frames with in_valid held high are both accepted in order.
- Reset mid-COMPUTE at cycle 10 → next cycle out_valid=0, in_ready=1, out_flat=0. A new frame then completes correctly.

Source files
------------

// File: rtl/gnn_layer_seq.sv
// ----------------------------------------------------------------------------
// gnn_layer_seq
// Time-multiplexed single GCN layer built around one shared multiplier.
//   out[n][j] = sum_{m in {n} u N(n)} sum_i x[m][i] * w[i][j]
// followed by optional ReLU and saturation (or wrap) to OW signed bits.
//
// Ports
//   clk, rst        : rising-edge clock, synchronous active-high reset
//   in_valid/ready  : input frame handshake (ready only while idle)
//   x_flat          : x[n][i] at bit offset (n*FI+i)*DW, signed
//   w_flat          : w[i][j] at bit offset (i*FO+j)*WW, signed
//   adj             : bit n*N+m set when node m neighbours node n
//   relu_en         : clamp negative results to zero
//   out_valid/ready : output frame handshake
//   out_flat        : out[n][j] at bit offset (n*FO+j)*OW, signed
//   sat_flag        : some result of the frame saturated or wrapped
// ----------------------------------------------------------------------------
module gnn_layer_seq #(
    parameter int N   = 4,
    parameter int FI  = 4,
    parameter int FO  = 2,
    parameter int DW  = 5,
    parameter int WW  = 5,
    parameter int OW  = 21,
    parameter int SAT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N*FI*DW-1:0]    x_flat,
    input  logic [FI*FO*WW-1:0]   w_flat,
    input  logic [N*N-1:0]        adj,
    input  logic                  relu_en,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [N*FO*OW-1:0]    out_flat,
    output logic                  sat_flag
);

    localparam int NW    = (N  > 1) ? $clog2(N)  : 1;
    localparam int IW    = (FI > 1) ? $clog2(FI) : 1;
    localparam int JW    = (FO > 1) ? $clog2(FO) : 1;
    localparam int ACC_W = DW + WW + $clog2(FI) + $clog2(N) + 1;
    // Sum of up to N features needs clog2(N) extra bits; one more keeps margin.
    localparam int AGG_W = DW + $clog2(N) + 1;
    localparam int PW    = AGG_W + WW;
    // Post-processing width: wide enough for both the accumulator and OW range.
    localparam int EW    = ((ACC_W > OW) ? ACC_W : OW) + 1;

    localparam logic signed [EW-1:0] OMAX = {{(EW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [EW-1:0] OMIN = ~OMAX;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COMPUTE = 2'd1;
    localparam logic [1:0] S_DONE    = 2'd2;

    localparam logic [NW-1:0] N_LAST = NW'(N - 1);
    localparam logic [IW-1:0] I_LAST = IW'(FI - 1);
    localparam logic [JW-1:0] J_LAST = JW'(FO - 1);

    // ReLU first, then fit to OW bits. Returns {out_of_range, value}.
    function automatic logic [OW:0] post_proc(input logic signed [ACC_W-1:0] v,
                                              input logic relu);
        logic signed [EW-1:0] e;
        logic [OW:0]          r;
        e = EW'(v);
        if (relu && e[EW-1])
            e = '0;
        if (e > OMAX)
            r = {1'b1, (SAT != 0) ? OMAX[OW-1:0] : e[OW-1:0]};
        else if (e < OMIN)
            r = {1'b1, (SAT != 0) ? OMIN[OW-1:0] : e[OW-1:0]};
        else
            r = {1'b0, e[OW-1:0]};
        return r;
    endfunction

    logic [1:0]               r_state;
    logic [N*FI*DW-1:0]       r_x;
    logic [FI*FO*WW-1:0]      r_w;
    logic [N*N-1:0]           r_adj;
    logic                     r_relu;
    logic [NW-1:0]            r_n;
    logic [JW-1:0]            r_j;
    logic [IW-1:0]            r_i;
    logic signed [ACC_W-1:0]  r_acc;
    logic [N*FO*OW-1:0]       r_shadow;
    logic [N*FO*OW-1:0]       r_out;
    logic                     r_sat;

    logic signed [AGG_W-1:0]  w_agg;
    logic signed [WW-1:0]     w_wt;
    logic signed [PW-1:0]     w_prod;
    logic signed [ACC_W-1:0]  w_acc_next;
    logic [OW:0]              w_post;
    logic [OW-1:0]            w_res;
    logic                     w_flag;
    logic                     w_accept;

    // Neighbourhood aggregation of feature i for the current node; self is
    // always included regardless of the adjacency diagonal.
    always_comb begin
        w_agg = '0;
        for (int m = 0; m < N; m++) begin
            if (m == int'(r_n) || r_adj[int'(r_n)*N + m])
                w_agg = w_agg + AGG_W'($signed(r_x[(m*FI + int'(r_i))*DW +: DW]));
        end
    end

    assign w_wt       = $signed(r_w[(int'(r_i)*FO + int'(r_j))*WW +: WW]);
    assign w_prod     = PW'(w_agg) * PW'(w_wt);
    assign w_acc_next = r_acc + ACC_W'(w_prod);
    assign w_post     = post_proc(w_acc_next, r_relu);
    assign w_res      = w_post[OW-1:0];
    assign w_flag     = w_post[OW];
    assign w_accept   = (r_state == S_IDLE) && in_valid;

    // Operand latches: only loaded on frame accept, so input changes while
    // busy never reach the datapath.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_x    <= x_flat;
            r_w    <= w_flat;
            r_adj  <= adj;
            r_relu <= relu_en;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_n      <= '0;
            r_j      <= '0;
            r_i      <= '0;
            r_acc    <= '0;
            r_shadow <= '0;
            r_out    <= '0;
            r_sat    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_n     <= '0;
                        r_j     <= '0;
                        r_i     <= '0;
                        r_acc   <= '0;
                        r_sat   <= 1'b0;
                        r_state <= S_COMPUTE;
                    end
                end
                S_COMPUTE: begin
                    if (r_i == I_LAST) begin
                        r_shadow[(int'(r_n)*FO + int'(r_j))*OW +: OW] <= w_res;
                        r_sat <= r_sat | w_flag;
                        r_acc <= '0;
                        r_i   <= '0;
                        if (r_j == J_LAST) begin
                            r_j <= '0;
                            if (r_n == N_LAST) begin
                                // Publish the frame: shadow plus the final
                                // result, which is not in the shadow yet.
                                r_out <= r_shadow;
                                r_out[(int'(r_n)*FO + int'(r_j))*OW +: OW] <= w_res;
                                r_n     <= '0;
                                r_state <= S_DONE;
                            end else begin
                                r_n <= r_n + NW'(1);
                            end
                        end else begin
                            r_j <= r_j + JW'(1);
                        end
                    end else begin
                        r_acc <= w_acc_next;
                        r_i   <= r_i + IW'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign out_flat  = r_out;
    assign sat_flag  = r_sat;

endmodule

// File: tb/tb_gnn_layer_seq.sv
// ----------------------------------------------------------------------------
// tb_gnn_layer_seq
// Bench for gnn_layer_seq. Three instances share all inputs: the default
// configuration (OW=21) plus OW=12 with saturation and OW=12 with wrap.
// Expected results come from a plain-arithmetic GCN model over integer arrays.
// ----------------------------------------------------------------------------
module tb_gnn_layer_seq;

    localparam int N   = 4;
    localparam int FI  = 4;
    localparam int FO  = 2;
    localparam int DW  = 5;
    localparam int WW  = 5;
    localparam int OW  = 21;
    localparam int OWS = 12;
    localparam int LAT = N*FO*FI + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst, in_valid, relu_en, out_ready;
    logic [N*FI*DW-1:0]   x_flat;
    logic [FI*FO*WW-1:0]  w_flat;
    logic [N*N-1:0]       adj;

    logic                 in_ready, out_valid, sat_flag;
    logic [N*FO*OW-1:0]   out_flat;
    logic                 in_ready_s, out_valid_s, sat_flag_s;
    logic [N*FO*OWS-1:0]  out_flat_s;
    logic                 in_ready_w, out_valid_w, sat_flag_w;
    logic [N*FO*OWS-1:0]  out_flat_w;

    gnn_layer_seq #(.N(N), .FI(FI), .FO(FO), .DW(DW), .WW(WW), .OW(OW), .SAT(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .x_flat(x_flat), .w_flat(w_flat), .adj(adj), .relu_en(relu_en),
        .out_valid(out_valid), .out_ready(out_ready), .out_flat(out_flat),
        .sat_flag(sat_flag));

    gnn_layer_seq #(.N(N), .FI(FI), .FO(FO), .DW(DW), .WW(WW), .OW(OWS), .SAT(1)) dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
        .x_flat(x_flat), .w_flat(w_flat), .adj(adj), .relu_en(relu_en),
        .out_valid(out_valid_s), .out_ready(out_ready), .out_flat(out_flat_s),
        .sat_flag(sat_flag_s));

    gnn_layer_seq #(.N(N), .FI(FI), .FO(FO), .DW(DW), .WW(WW), .OW(OWS), .SAT(0)) dut_w (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w),
        .x_flat(x_flat), .w_flat(w_flat), .adj(adj), .relu_en(relu_en),
        .out_valid(out_valid_w), .out_ready(out_ready), .out_flat(out_flat_w),
        .sat_flag(sat_flag_w));

    int errors = 0;
    int checks = 0;

    int gx[N][FI];
    int gw[FI][FO];
    bit gadj[N][N];
    bit grelu;

    // ---------------- reference model ----------------
    function automatic longint raw_out(int n, int j);
        longint s = 0;
        for (int m = 0; m < N; m++)
            if (m == n || gadj[n][m])
                for (int i = 0; i < FI; i++)
                    s += longint'(gx[m][i]) * longint'(gw[i][j]);
        if (grelu && s < 0) s = 0;
        return s;
    endfunction

    function automatic longint fit(longint s, int ow, bit sat, output bit f);
        longint hi = (longint'(1) <<< (ow - 1)) - 1;
        longint lo = -hi - 1;
        longint m;
        f = 1'b0;
        if (s > hi || s < lo) begin
            f = 1'b1;
            if (sat) return (s > hi) ? hi : lo;
            m = s & ((longint'(1) <<< ow) - 1);
            if (m > hi) m -= (longint'(1) <<< ow);
            return m;
        end
        return s;
    endfunction

    function automatic longint exp_out(int n, int j, int ow, bit sat);
        bit f;
        return fit(raw_out(n, j), ow, sat, f);
    endfunction

    function automatic bit exp_flag(int ow, bit sat);
        bit f, any;
        longint v;
        any = 1'b0;
        for (int n = 0; n < N; n++)
            for (int j = 0; j < FO; j++) begin
                v = fit(raw_out(n, j), ow, sat, f);
                any |= f;
            end
        return any;
    endfunction

    // ---------------- DUT output extraction ----------------
    function automatic longint got_m(int n, int j);
        logic signed [OW-1:0] v;
        v = out_flat[(n*FO + j)*OW +: OW];
        return longint'(v);
    endfunction

    function automatic longint got_s(int n, int j);
        logic signed [OWS-1:0] v;
        v = out_flat_s[(n*FO + j)*OWS +: OWS];
        return longint'(v);
    endfunction

    function automatic longint got_w(int n, int j);
        logic signed [OWS-1:0] v;
        v = out_flat_w[(n*FO + j)*OWS +: OWS];
        return longint'(v);
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_inputs();
        for (int n = 0; n < N; n++)
            for (int i = 0; i < FI; i++)
                x_flat[(n*FI + i)*DW +: DW] = DW'(gx[n][i]);
        for (int i = 0; i < FI; i++)
            for (int j = 0; j < FO; j++)
                w_flat[(i*FO + j)*WW +: WW] = WW'(gw[i][j]);
        for (int n = 0; n < N; n++)
            for (int m = 0; m < N; m++)
                adj[n*N + m] = gadj[n][m];
        relu_en = grelu;
    endtask

    task automatic set_ring();
        for (int n = 0; n < N; n++)
            for (int m = 0; m < N; m++)
                gadj[n][m] = (m == (n + 1) % N) || (m == (n + N - 1) % N);
    endtask

    task automatic set_uniform(int xv, int wv);
        for (int n = 0; n < N; n++)
            for (int i = 0; i < FI; i++) gx[n][i] = xv;
        for (int i = 0; i < FI; i++)
            for (int j = 0; j < FO; j++) gw[i][j] = wv;
    endtask

    task automatic set_random();
        for (int n = 0; n < N; n++)
            for (int i = 0; i < FI; i++) gx[n][i] = int'($urandom_range(0, 31)) - 16;
        for (int i = 0; i < FI; i++)
            for (int j = 0; j < FO; j++) gw[i][j] = int'($urandom_range(0, 31)) - 16;
        for (int n = 0; n < N; n++)
            for (int m = 0; m < N; m++) gadj[n][m] = 1'($urandom_range(0, 1));
        grelu = 1'($urandom_range(0, 1));
    endtask

    // Waits for out_valid; lat is the number of the edge after accept at
    // which out_valid is first sampled high. An expired bound counts as a FAIL.
    task automatic wait_done(input bit scramble, output int lat);
        int k = 0;
        while (!out_valid && k < 200) begin
            if (scramble) begin
                for (int b = 0; b < N*FI*DW; b++) x_flat[b] = 1'($urandom_range(0, 1));
                for (int b = 0; b < FI*FO*WW; b++) w_flat[b] = 1'($urandom_range(0, 1));
                for (int b = 0; b < N*N; b++) adj[b] = 1'($urandom_range(0, 1));
                relu_en = 1'($urandom_range(0, 1));
            end
            tick();
            k++;
        end
        lat = k + 1;
        if (!out_valid) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: out_valid=%0b after %0d cycles, required 1", out_valid, k);
        end
    endtask

    task automatic run_to_done(input bit scramble, output int lat);
        int g = 0;
        drive_inputs();
        in_valid = 1'b1;
        while (!in_ready && g < 100) begin tick(); g++; end
        tick();
        in_valid = 1'b0;
        wait_done(scramble, lat);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        set_uniform(0, 0); set_ring(); grelu = 1'b0; drive_inputs();
        tick(); tick();
        checks += 4;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
        if (out_flat !== '0) begin errors++; $display("FAIL reset_out_flat: got %h want 0", out_flat); end
        if (sat_flag !== 1'b0) begin errors++; $display("FAIL reset_sat_flag: got %0b want 0", sat_flag); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_max();
        int lat;
        set_uniform(15, 15); set_ring(); grelu = 1'b0;
        run_to_done(1'b0, lat);
        checks++;
        if (lat !== LAT) begin errors++; $display("FAIL max_latency: got %0d want %0d", lat, LAT); end
        for (int n = 0; n < N; n++)
            for (int j = 0; j < FO; j++) begin
                checks++;
                if (got_m(n, j) !== 64'sd2700) begin
                    errors++; $display("FAIL max_out[%0d][%0d]: got %0d want 2700", n, j, got_m(n, j));
                end
            end
        checks++;
        if (sat_flag !== 1'b0) begin errors++; $display("FAIL max_sat_flag: got %0b want 0", sat_flag); end
        tick();
    endtask

    task automatic test_min();
        int lat;
        set_uniform(-16, -16); set_ring(); grelu = 1'b0;
        run_to_done(1'b0, lat);
        for (int n = 0; n < N; n++)
            for (int j = 0; j < FO; j++) begin
                checks += 3;
                if (got_m(n, j) !== 64'sd3072) begin
                    errors++; $display("FAIL min_out[%0d][%0d]: got %0d want 3072", n, j, got_m(n, j));
                end
                if (got_s(n, j) !== 64'sd2047) begin
                    errors++; $display("FAIL min_sat_out[%0d][%0d]: got %0d want 2047", n, j, got_s(n, j));
                end
                if (got_w(n, j) !== -64'sd1024) begin
                    errors++; $display("FAIL min_wrap_out[%0d][%0d]: got %0d want -1024", n, j, got_w(n, j));
                end
            end
        checks += 3;
        if (sat_flag !== 1'b0) begin errors++; $display("FAIL min_sat_flag: got %0b want 0", sat_flag); end
        if (sat_flag_s !== 1'b1) begin errors++; $display("FAIL min_sat_flag_s: got %0b want 1", sat_flag_s); end
        if (sat_flag_w !== 1'b1) begin errors++; $display("FAIL min_sat_flag_w: got %0b want 1", sat_flag_w); end
        tick();
    endtask

    task automatic test_relu();
        int lat;
        for (int r = 0; r < 2; r++) begin
            set_uniform(1, 0); set_ring(); grelu = 1'(r);
            for (int i = 0; i < FI; i++) begin gw[i][0] = -1; gw[i][1] = 2; end
            run_to_done(1'b0, lat);
            for (int n = 0; n < N; n++)
                for (int j = 0; j < FO; j++) begin
                    checks++;
                    if (got_m(n, j) !== exp_out(n, j, OW, 1'b1)) begin
                        errors++; $display("FAIL relu%0d_out[%0d][%0d]: got %0d want %0d",
                                           r, n, j, got_m(n, j), exp_out(n, j, OW, 1'b1));
                    end
                end
            tick();
        end
    endtask

    task automatic test_adjacency();
        int lat;
        for (int f = 0; f < 2; f++) begin
            set_uniform(0, 1); grelu = 1'b0;
            for (int n = 0; n < N; n++) begin
                for (int i = 0; i < FI; i++) gx[n][i] = n + 1;
                for (int m = 0; m < N; m++) gadj[n][m] = 1'(f);
            end
            run_to_done(1'b0, lat);
            for (int n = 0; n < N; n++)
                for (int j = 0; j < FO; j++) begin
                    checks++;
                    if (got_m(n, j) !== exp_out(n, j, OW, 1'b1)) begin
                        errors++; $display("FAIL adj%0d_out[%0d][%0d]: got %0d want %0d",
                                           f, n, j, got_m(n, j), exp_out(n, j, OW, 1'b1));
                    end
                end
            tick();
        end
    endtask

    task automatic test_random();
        int lat;
        for (int t = 0; t < 6; t++) begin
            set_random();
            run_to_done(1'b0, lat);
            for (int n = 0; n < N; n++)
                for (int j = 0; j < FO; j++) begin
                    checks += 3;
                    if (got_m(n, j) !== exp_out(n, j, OW, 1'b1)) begin
                        errors++; $display("FAIL rand%0d_out[%0d][%0d]: got %0d want %0d",
                                           t, n, j, got_m(n, j), exp_out(n, j, OW, 1'b1));
                    end
                    if (got_s(n, j) !== exp_out(n, j, OWS, 1'b1)) begin
                        errors++; $display("FAIL rand%0d_sat_out[%0d][%0d]: got %0d want %0d",
                                           t, n, j, got_s(n, j), exp_out(n, j, OWS, 1'b1));
                    end
                    if (got_w(n, j) !== exp_out(n, j, OWS, 1'b0)) begin
                        errors++; $display("FAIL rand%0d_wrap_out[%0d][%0d]: got %0d want %0d",
                                           t, n, j, got_w(n, j), exp_out(n, j, OWS, 1'b0));
                    end
                end
            checks += 2;
            if (sat_flag_s !== exp_flag(OWS, 1'b1)) begin
                errors++; $display("FAIL rand%0d_sat_flag_s: got %0b want %0b", t, sat_flag_s, exp_flag(OWS, 1'b1));
            end
            if (sat_flag_w !== exp_flag(OWS, 1'b0)) begin
                errors++; $display("FAIL rand%0d_sat_flag_w: got %0b want %0b", t, sat_flag_w, exp_flag(OWS, 1'b0));
            end
            tick();
        end
    endtask

    // Inputs are scrambled during COMPUTE, then the result is held under
    // backpressure for 10 cycles.
    task automatic test_backpressure();
        int lat;
        logic [N*FO*OW-1:0] snap;
        set_random();
        out_ready = 1'b0;
        run_to_done(1'b1, lat);
        snap = out_flat;
        for (int n = 0; n < N; n++)
            for (int j = 0; j < FO; j++) begin
                checks++;
                if (got_m(n, j) !== exp_out(n, j, OW, 1'b1)) begin
                    errors++; $display("FAIL bp_out[%0d][%0d]: got %0d want %0d",
                                       n, j, got_m(n, j), exp_out(n, j, OW, 1'b1));
                end
            end
        for (int c = 0; c < 10; c++) begin
            tick();
            checks += 3;
            if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid c%0d: got %0b want 1", c, out_valid); end
            if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold_in_ready c%0d: got %0b want 0", c, in_ready); end
            if (out_flat !== snap) begin errors++; $display("FAIL bp_hold_out c%0d: got %h want %h", c, out_flat, snap); end
        end
        out_ready = 1'b1;
        tick();
        checks += 3;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid: got %0b want 0", out_valid); end
        if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready: got %0b want 1", in_ready); end
        if (out_flat !== snap) begin errors++; $display("FAIL bp_after_hs_out: got %h want %h", out_flat, snap); end
        drive_inputs();
    endtask

    task automatic test_back_to_back();
        int lat, g;
        longint expa[N][FO];
        set_random();
        for (int n = 0; n < N; n++)
            for (int j = 0; j < FO; j++) expa[n][j] = exp_out(n, j, OW, 1'b1);
        drive_inputs();
        in_valid = 1'b1;
        g = 0;
        while (!in_ready && g < 100) begin tick(); g++; end
        tick();
        set_random();
        drive_inputs();
        wait_done(1'b0, lat);
        for (int n = 0; n < N; n++)
            for (int j = 0; j < FO; j++) begin
                checks++;
                if (got_m(n, j) !== expa[n][j]) begin
                    errors++; $display("FAIL b2b_a_out[%0d][%0d]: got %0d want %0d", n, j, got_m(n, j), expa[n][j]);
                end
            end
        tick();
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_idle_in_ready: got %0b want 1", in_ready); end
        tick();
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_second_accept: in_ready got %0b want 0", in_ready); end
        in_valid = 1'b0;
        wait_done(1'b0, lat);
        for (int n = 0; n < N; n++)
            for (int j = 0; j < FO; j++) begin
                checks++;
                if (got_m(n, j) !== exp_out(n, j, OW, 1'b1)) begin
                    errors++; $display("FAIL b2b_b_out[%0d][%0d]: got %0d want %0d",
                                       n, j, got_m(n, j), exp_out(n, j, OW, 1'b1));
                end
            end
        tick();
    endtask

    task automatic test_reset_mid();
        int lat, g;
        set_random();
        drive_inputs();
        in_valid = 1'b1;
        g = 0;
        while (!in_ready && g < 100) begin tick(); g++; end
        tick();
        in_valid = 1'b0;
        repeat (10) tick();
        rst = 1'b1;
        tick();
        checks += 3;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid: got %0b want 0", out_valid); end
        if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready: got %0b want 1", in_ready); end
        if (out_flat !== '0) begin errors++; $display("FAIL rstmid_out_flat: got %h want 0", out_flat); end
        rst = 1'b0;
        set_random();
        run_to_done(1'b0, lat);
        checks++;
        if (lat !== LAT) begin errors++; $display("FAIL rstmid_latency: got %0d want %0d", lat, LAT); end
        for (int n = 0; n < N; n++)
            for (int j = 0; j < FO; j++) begin
                checks++;
                if (got_m(n, j) !== exp_out(n, j, OW, 1'b1)) begin
                    errors++; $display("FAIL rstmid_out[%0d][%0d]: got %0d want %0d",
                                       n, j, got_m(n, j), exp_out(n, j, OW, 1'b1));
                end
            end
        tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; relu_en = 1'b0;
        x_flat = '0; w_flat = '0; adj = '0;
        test_reset();
        test_max();
        test_min();
        test_relu();
        test_adjacency();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
